// File: rtl/noobs_prefetch_ifetch_pkg.sv
// Shared constants and helpers for the NoobsCpu prefetching fetch unit.
package noobs_prefetch_ifetch_pkg;

  // Core-wide defaults for the instruction side.
  localparam int NOOBS_AW         = 12;
  localparam int NOOBS_DW         = 8;
  localparam int NOOBS_RESET_ADDR = 0;

  // What happens to a memory response in the current cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_PUSH = 2'd1,
    RESP_DROP = 2'd2
  } resp_kind_e;

  // Ceiling log2, usable in constant expressions for counter and pointer widths.
  function automatic int noobs_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/noobs_prefetch_ifetch_sync_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the
// pointers wrap naturally. The head entry is presented combinationally.
module noobs_sync_fifo
  import noobs_prefetch_ifetch_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [WIDTH-1:0]              wdata_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic [noobs_clog2(DEPTH):0]   count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int PW = noobs_clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; flush wins over push and pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PW'(1);
      if (do_pop)  rptr_d = rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/noobs_prefetch_ifetch.sv
// Prefetching instruction fetch unit: keeps up to DEPTH reads in flight
// against an in-order, variable-latency instruction memory, queues the
// returned words with their addresses, and drops stale responses after a
// branch redirect.
module noobs_prefetch_ifetch
  import noobs_prefetch_ifetch_pkg::*;
#(
  parameter int            AW         = NOOBS_AW,
  parameter int            DW         = NOOBS_DW,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = AW'(NOOBS_RESET_ADDR)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_en,
  input  logic          branch,
  input  logic [AW-1:0] tgt_addr,
  output logic          i_req,
  output logic [AW-1:0] i_addr,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          inst_vld,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr,
  output logic [AW-1:0] next_addr,
  input  logic          inst_rdy,
  output logic          busy
);

  localparam int CW = noobs_clog2(DEPTH) + 1;

  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    drop_cnt_q, drop_cnt_d;

  logic             issue;
  logic             credit_ok;
  logic [CW:0]      credits_used;
  resp_kind_e       resp_kind;

  logic             q_push, q_pop, q_flush;
  logic [AW+DW-1:0] q_wdata, q_rdata;
  logic [CW-1:0]    q_count;
  logic             q_full, q_empty;

  logic [AW-1:0]    tag_head;
  logic [CW-1:0]    tag_count;
  logic             tag_full, tag_empty;

  // Every queued entry plus every read in flight holds one credit, so a
  // response always finds room in the instruction queue.
  assign credits_used = {1'b0, q_count} + {1'b0, outstanding_q};
  assign credit_ok    = (credits_used < (CW+1)'(DEPTH));

  assign issue  = fetch_en & ~branch & ~reset & credit_ok;
  assign i_req  = issue;
  assign i_addr = fetch_pc_q;

  // Classify the response: anything arriving during a branch or while stale
  // reads are still draining is discarded.
  always_comb begin
    resp_kind = RESP_NONE;
    if (i_vld) begin
      if (branch || (drop_cnt_q != '0)) resp_kind = RESP_DROP;
      else                              resp_kind = RESP_PUSH;
    end
  end

  assign q_push  = (resp_kind == RESP_PUSH);
  assign q_pop   = inst_vld & inst_rdy & ~branch;
  assign q_flush = branch;
  assign q_wdata = {tag_head, i_data};

  // Address tags follow the reads in issue order; every response retires one
  // tag whether it is kept or dropped, so this FIFO is never flushed.
  noobs_sync_fifo #(
    .WIDTH (AW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (issue),
    .pop_i   (i_vld),
    .flush_i (1'b0),
    .wdata_i (fetch_pc_q),
    .rdata_o (tag_head),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  noobs_sync_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (q_flush),
    .wdata_i (q_wdata),
    .rdata_o (q_rdata),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Next fetch address, in-flight count and stale-response count.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (branch)     fetch_pc_d = tgt_addr;
    else if (issue) fetch_pc_d = fetch_pc_q + AW'(1);

    case ({issue, i_vld})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    // Reads already marked stale are a subset of those in flight, so after a
    // redirect every read still in flight is stale; this keeps back-to-back
    // branches from counting the same read twice.
    if (branch)                            drop_cnt_d = outstanding_q - CW'(i_vld);
    else if (i_vld && drop_cnt_q != '0)    drop_cnt_d = drop_cnt_q - CW'(1);
  end

  // Fetch state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_ADDR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign inst_vld  = ~q_empty;
  assign inst_o    = q_empty ? '0 : q_rdata[DW-1:0];
  assign inst_addr = q_empty ? '0 : q_rdata[AW+DW-1:DW];
  assign next_addr = inst_addr + AW'(1);
  assign busy      = (outstanding_q != '0) || (drop_cnt_q != '0);

  // Credit accounting must make these impossible.
  a_no_queue_overflow: assert property (@(posedge clk) disable iff (reset)
    q_push |-> !q_full);
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (reset)
    issue |-> !tag_full);
  a_resp_has_tag: assert property (@(posedge clk) disable iff (reset)
    i_vld |-> !tag_empty);
  a_tags_match_inflight: assert property (@(posedge clk) disable iff (reset)
    tag_count == outstanding_q);

endmodule
